ext_burst_drain: RTL and testbench
==================================

# ext_burst_drain

Read-side companion of the ext-unit elastic buffer. It accepts burst commands, each giving a beat count. For each command it drains exactly that many words from the buffer's valid/ready output and emits them as a write-data stream with a `last` flag. It tracks outstanding bursts against write responses and back-pressures new commands at a configurable limit. It sits between the ext buffer and the external write port of the DMA ext unit.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of data words.
- `LEN_WIDTH`, 8, width of the command length field. Length is encoded as beats minus 1, so a burst is 1..2^LEN_WIDTH beats.
- `MAX_OUTSTANDING`, 4, maximum number of commands accepted but not yet responded. Must be ≥1.
- `CNT_WIDTH`, `$clog2(MAX_OUTSTANDING+1)`, derived width of the outstanding counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `cmd_valid_i` in 1: command valid.
- `cmd_len_i` in LEN_WIDTH: beats minus 1.
- `cmd_ready_o` out 1: command accepted when both valid and ready are high.
- `buf_valid_i` in 1: buffer has a word.
- `buf_data_i` in DATA_WIDTH: buffer head word.
- `buf_ready_o` out 1: pop the buffer head.
- `w_valid_o` out 1: write beat valid.
- `w_data_o` out DATA_WIDTH: write beat data.
- `w_last_o` out 1: final beat of the burst.
- `w_ready_i` in 1: downstream accepts the beat.
- `b_valid_i` in 1: write response valid.
- `b_ready_o` out 1: response accepted.
- `outstanding_o` out CNT_WIDTH: commands accepted minus responses received.
- `busy_o` out 1: state is BURST, or `outstanding_o` ≠ 0.

## Operation
State machine with two states, IDLE and BURST.
- IDLE:
  - `cmd_ready_o` = (`outstanding_o` < MAX_OUTSTANDING).
  - On a command handshake: load `beat_cnt` ← `cmd_len_i`, increment the outstanding counter, go to BURST.
- BURST:
  - `cmd_ready_o` = 0.
  - Each beat popped from the buffer (`buf_valid_i && buf_ready_o`) decrements `beat_cnt`.
  - The pop with `beat_cnt`==0 is the last beat. That beat is tagged last, and the FSM returns to IDLE on that edge.
- Beat count: the number of words popped per command is exactly `cmd_len_i`+1. The block never pops words outside BURST.
- Responses:
  - `b_ready_o` = (`outstanding_o` ≠ 0).
  - A response handshake decrements the counter.
  - If a command handshake and a response handshake happen in the same cycle, the counter is unchanged.
  - The counter cannot underflow (no ready at 0) and cannot overflow (no command accepted at MAX).
- Response-before-data ordering is the downstream's responsibility and is not checked.
- Words in the buffer are never dropped or reordered.

## Timing
- Reset values:
  - state IDLE, `beat_cnt`=0, `outstanding_o`=0.
  - `w_valid_o`=0, `w_last_o`=0, `w_data_o`=0.
  - `buf_ready_o`=0, `b_ready_o`=0, `busy_o`=0.
  - `cmd_ready_o`=1.
- Command to first beat:
  - The command handshake at edge N puts the FSM in BURST from cycle N+1.
  - The first beat can be popped in cycle N+1.
- Between bursts: at least one cycle elapses between the last-beat pop and the next command handshake, because IDLE is entered on that edge.
- Full throughput within a burst: one beat per cycle while `buf_valid_i` and `w_ready_i` are both high.
- `cmd_len_i` = 2^LEN_WIDTH−1 gives a maximum-length burst. `beat_cnt` must not wrap before the last beat.
- Reset asserted mid-burst: all state clears immediately. The remainder of the burst is abandoned, and any words left in the buffer are not popped.

## Configuration
`EXT_BURST_DRAIN_OUTREG_EN` selects how the write channel is driven.
- Undefined: combinational pass-through in BURST.
  - `w_valid_o` = `buf_valid_i`, `w_data_o` = `buf_data_i`, `buf_ready_o` = `w_ready_i`.
  - `w_last_o` = (`beat_cnt`==0).
  - Outside BURST, `w_valid_o` = 0 and `buf_ready_o` = 0.
  - Zero latency.
- Defined: a one-entry output register holds data, valid and last.
  - `buf_ready_o` = BURST && (!`w_valid_o` || `w_ready_i`).
  - Each pop loads the register on the next edge, so there is 1 cycle of added latency with full throughput.
  - The register drains normally after the FSM has returned to IDLE.
  - `busy_o` also stays high while the register is valid.

## Test plan
- Single beat: reset, then `cmd_len_i`=0 and buffer holds 0xA5. Exactly one beat 0xA5 is emitted with `w_last_o`=1, `outstanding_o`=1. After the response, `outstanding_o`=0 and `busy_o`=0.
- Four-beat burst with back-pressure: `cmd_len_i`=3, buffer words 1..4, `w_ready_i` toggling 1,0,1,0. Beats 1..4 are emitted in order, `last` only on beat 4, no beat is lost or duplicated.
- Outstanding limit: 4 one-beat commands with no responses, then a 5th command. `cmd_ready_o`=0 for the 5th. One response makes `cmd_ready_o`=1 the next cycle.
- Simultaneous events: a command handshake and a response handshake in the same cycle with `outstanding_o`=2 → `outstanding_o` stays 2.
- Maximum length: `cmd_len_i`=255 gives 256 beats with `last` only on the 256th. A word pushed afterwards is not popped.
- Reset mid-burst: `cmd_len_i`=7, reset asserted after 3 beats. All outputs take their reset values, and the following burst starts from a fresh count.

Source files
------------

// File: rtl/ext_burst_drain.sv
// ext_burst_drain
// ---------------------------------------------------------------------------
// Read-side companion of the ext-unit elastic buffer. Each accepted burst
// command (length = beats - 1) drains exactly that many words from the buffer
// valid/ready output. The words are re-emitted as a write-data stream with a
// last flag. Commands that have been accepted but not yet answered by a write
// response are counted. New commands are held off once that count reaches
// MAX_OUTSTANDING.
//
// Handshake rule (all channels): a transfer happens on a rising clk_i edge
// where valid and ready are both high. Once valid is raised by a producer, it
// is not required to stay up; ready may depend combinationally on valid-side
// state but never on the partner's valid in the same channel.
//
// Build option:
//   EXT_BURST_DRAIN_OUTREG_EN  - when defined, the write channel is driven
//                                from a one-entry output register (1 cycle of
//                                latency, full throughput). When undefined,
//                                the buffer head passes straight through
//                                during BURST.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid_i/cmd_len_i   burst command (beats - 1)
//   cmd_ready_o             command accept
//   buf_valid_i/buf_data_i  buffer head word
//   buf_ready_o             pop the buffer head
//   w_valid_o/w_data_o      write beat
//   w_last_o                final beat of a burst
//   w_ready_i               downstream accepts the beat
//   b_valid_i/b_ready_o     write response channel
//   outstanding_o           commands accepted minus responses received
//   busy_o                  burst in progress or responses pending
//   state_o                 FSM state (0 = IDLE, 1 = BURST), debug visibility
// ---------------------------------------------------------------------------
module ext_burst_drain #(
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  cmd_ready_o,
    input  logic                  buf_valid_i,
    input  logic [DATA_WIDTH-1:0] buf_data_i,
    output logic                  buf_ready_o,
    output logic                  w_valid_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic                  w_last_o,
    input  logic                  w_ready_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  busy_o,
    output logic                  state_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [0:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] outstanding_q;
    logic                 in_burst;
    logic                 cmd_hs;
    logic                 b_hs;
    logic                 pop;

    assign in_burst      = (state_q == ST_BURST);
    assign cmd_ready_o   = !in_burst && (outstanding_q < MAX_CNT);
    assign b_ready_o     = (outstanding_q != '0);
    assign cmd_hs        = cmd_valid_i && cmd_ready_o;
    assign b_hs          = b_valid_i && b_ready_o;
    assign pop           = buf_valid_i && buf_ready_o;
    assign outstanding_o = outstanding_q;
    assign state_o       = state_q[0];

    // beat_cnt holds the number of beats still to pop after the current one,
    // so the pop seen with beat_cnt == 0 is the last one. The counter is
    // never decremented on that pop, so a maximum-length burst cannot wrap.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (!in_burst) begin
            if (cmd_hs) begin
                state_d    = ST_BURST;
                beat_cnt_d = cmd_len_i;
            end
        end else if (pop) begin
            if (beat_cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // A simultaneous command and response cancel out. Ready gating on both
    // sides keeps the counter within 0..MAX_OUTSTANDING.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (cmd_hs && !b_hs) begin
            outstanding_q <= outstanding_q + CNT_WIDTH'(1);
        end else if (b_hs && !cmd_hs) begin
            outstanding_q <= outstanding_q - CNT_WIDTH'(1);
        end
    end

`ifdef EXT_BURST_DRAIN_OUTREG_EN
    logic                  w_valid_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic                  w_last_q;

    // Pop only when the register is empty or being emptied this cycle.
    assign buf_ready_o = in_burst && (!w_valid_q || w_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
            w_last_q  <= 1'b0;
        end else if (pop) begin
            w_valid_q <= 1'b1;
            w_data_q  <= buf_data_i;
            w_last_q  <= (beat_cnt_q == '0);
        end else if (w_ready_i) begin
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
        end
    end

    assign w_valid_o = w_valid_q;
    assign w_data_o  = w_data_q;
    assign w_last_o  = w_last_q;
    // The register may still hold the final beat after the FSM is in IDLE.
    assign busy_o    = in_burst || (outstanding_q != '0) || w_valid_q;
`else
    // Zero-latency pass-through; everything is gated off outside BURST.
    assign buf_ready_o = in_burst && w_ready_i;
    assign w_valid_o   = in_burst && buf_valid_i;
    assign w_data_o    = in_burst ? buf_data_i : '0;
    assign w_last_o    = in_burst && (beat_cnt_q == '0);
    assign busy_o      = in_burst || (outstanding_q != '0);
`endif

endmodule

// File: tb/tb_ext_burst_drain.sv
// tb_ext_burst_drain
// ---------------------------------------------------------------------------
// Directed and randomized checks of ext_burst_drain in its default
// (pass-through) build. The buffer is modelled as a queue of words, and the
// expected write stream is derived from the words pushed and the command
// lengths issued.
// ---------------------------------------------------------------------------
module tb_ext_burst_drain;

  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int MAXO = 4;
  localparam int CW  = $clog2(MAXO + 1);

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          cmd_valid_i = 1'b0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          cmd_ready_o;
  logic          buf_valid_i = 1'b0;
  logic [DW-1:0] buf_data_i = '0;
  logic          buf_ready_o;
  logic          w_valid_o;
  logic [DW-1:0] w_data_o;
  logic          w_last_o;
  logic          w_ready_i = 1'b0;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [CW-1:0] outstanding_o;
  logic          busy_o;
  logic          state_o;

  ext_burst_drain #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_len_i(cmd_len_i), .cmd_ready_o(cmd_ready_o),
    .buf_valid_i(buf_valid_i), .buf_data_i(buf_data_i), .buf_ready_o(buf_ready_o),
    .w_valid_o(w_valid_o), .w_data_o(w_data_o), .w_last_o(w_last_o), .w_ready_i(w_ready_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] buf_q[$];     // words held by the modelled buffer
  logic [DW-1:0] got_d_q[$];   // beats observed on the write channel
  logic          got_l_q[$];
  int  gap_pct = 0;            // chance of buf_valid_i dropping while words exist
  int  mdl_out = 0;            // commands accepted minus responses received
  bit  s_chs, s_bhs, s_pop;

  // ---------------- driver tasks ----------------
  task automatic drive_buf();
    if (buf_q.size() > 0) begin
      buf_data_i  = buf_q[0];
      buf_valid_i = ($urandom_range(0, 99) >= gap_pct);
    end else begin
      buf_data_i  = '0;
      buf_valid_i = 1'b0;
    end
  endtask

  // Observe handshakes at the falling edge, ahead of the edge that commits them.
  task automatic sample();
    @(negedge clk_i);
    s_chs = cmd_valid_i && cmd_ready_o;
    s_bhs = b_valid_i && b_ready_o;
    s_pop = buf_valid_i && buf_ready_o;
    if (w_valid_o && w_ready_i) begin
      got_d_q.push_back(w_data_o);
      got_l_q.push_back(w_last_o);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    if (rst_ni) mdl_out = mdl_out + int'(s_chs) - int'(s_bhs);
    if (s_pop && buf_q.size() > 0) void'(buf_q.pop_front());
    drive_buf();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    buf_q.push_back(w);
    drive_buf();
  endtask

  task automatic do_cmd(input int len);
    int cyc = 0;
    bit done = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = LW'(len);
    while (!done && cyc < 50) begin
      sample();
      done = s_chs;
      advance();
      cyc++;
    end
    cmd_valid_i = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL cmd_timeout: no command handshake in %0d cycles, required one", cyc);
    end
  endtask

  // mode 0: always ready, 1: toggle 1,0,1,0, 2: random
  task automatic drain_beats(input int n, input int mode, input int budget);
    int cyc = 0;
    while (got_d_q.size() < n && cyc < budget) begin
      case (mode)
        0:       w_ready_i = 1'b1;
        1:       w_ready_i = (cyc % 2 == 0);
        default: w_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      sample();
      advance();
      cyc++;
    end
    w_ready_i = 1'b1;
    n_vec++;
    if (got_d_q.size() < n) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d beats, required %0d", got_d_q.size(), n);
    end
  endtask

  task automatic respond(input int n);
    int cyc = 0;
    int seen = 0;
    b_valid_i = 1'b1;
    while (seen < n && cyc < 50) begin
      sample();
      if (s_bhs) seen++;
      advance();
      cyc++;
    end
    b_valid_i = 1'b0;
    n_vec++;
    if (seen < n) begin
      n_err++;
      $display("FAIL resp_timeout: %0d responses taken, required %0d", seen, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    push_word(32'hDEAD_BEEF);
    w_ready_i = 1'b1;
    cmd_valid_i = 1'b0;
    sample();
    n_vec++;
    if ({w_valid_o, w_last_o, buf_ready_o, b_ready_o, busy_o, cmd_ready_o} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_ctrl: {wv,wl,br,bk,busy,cr}=%b, required 000001",
               {w_valid_o, w_last_o, buf_ready_o, b_ready_o, busy_o, cmd_ready_o});
    end
    n_vec++;
    if (w_data_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: w_data_o=%h, required 0", w_data_o);
    end
    n_vec++;
    if (outstanding_o !== '0) begin
      n_err++;
      $display("FAIL reset_outstanding: %0d, required 0", outstanding_o);
    end
    advance();
    rst_ni = 1'b1;
    buf_q.delete();
    drive_buf();
    mdl_out = 0;
    advance();
  endtask

  task automatic test_single_beat();
    got_d_q.delete(); got_l_q.delete();
    w_ready_i = 1'b1;
    push_word(32'h0000_00A5);
    do_cmd(0);
    // Cycle N+1: the single beat is already on the bus.
    sample();
    n_vec++;
    if ({w_valid_o, w_last_o, w_data_o} !== {1'b1, 1'b1, 32'h0000_00A5}) begin
      n_err++;
      $display("FAIL single_first_beat: v=%b l=%b d=%h, required v=1 l=1 d=000000a5",
               w_valid_o, w_last_o, w_data_o);
    end
    advance();
    n_vec++;
    if (got_d_q.size() != 1 || got_d_q[0] !== 32'hA5 || got_l_q[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_beats: %0d beats, required exactly one A5 with last", got_d_q.size());
    end
    sample();
    n_vec++;
    if (outstanding_o !== CW'(1) || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_pending: outstanding=%0d busy=%b, required 1 and 1", outstanding_o, busy_o);
    end
    advance();
    respond(1);
    sample();
    n_vec++;
    if (outstanding_o !== '0 || busy_o !== 1'b0 || b_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: outstanding=%0d busy=%b b_ready=%b, required 0 0 0",
               outstanding_o, busy_o, b_ready_o);
    end
    advance();
  endtask

  task automatic test_backpressure();
    got_d_q.delete(); got_l_q.delete();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    do_cmd(3);
    drain_beats(4, 1, 40);
    // Let any stray extra beat show up before comparing counts.
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    n_vec++;
    if (got_d_q.size() != 4) begin
      n_err++;
      $display("FAIL bp_count: %0d beats, required 4", got_d_q.size());
    end
    for (int i = 0; i < 4 && i < got_d_q.size(); i++) begin
      n_vec++;
      if (got_d_q[i] !== DW'(i + 1) || got_l_q[i] !== (i == 3)) begin
        n_err++;
        $display("FAIL bp_beat%0d: data=%h last=%b, required data=%h last=%b",
                 i, got_d_q[i], got_l_q[i], DW'(i + 1), (i == 3));
      end
    end
    respond(1);
  endtask

  task automatic test_outstanding_limit();
    for (int i = 0; i < MAXO; i++) begin
      got_d_q.delete(); got_l_q.delete();
      push_word($urandom);
      do_cmd(0);
      drain_beats(1, 0, 20);
    end
    cmd_valid_i = 1'b1;
    cmd_len_i   = '0;
    sample();
    n_vec++;
    if (cmd_ready_o !== 1'b0 || outstanding_o !== CW'(MAXO)) begin
      n_err++;
      $display("FAIL limit_block: cmd_ready=%b outstanding=%0d, required 0 and %0d",
               cmd_ready_o, outstanding_o, MAXO);
    end
    advance();
    cmd_valid_i = 1'b0;
    b_valid_i   = 1'b1;
    sample();
    advance();
    b_valid_i = 1'b0;
    sample();
    n_vec++;
    if (cmd_ready_o !== 1'b1 || outstanding_o !== CW'(MAXO - 1)) begin
      n_err++;
      $display("FAIL limit_release: cmd_ready=%b outstanding=%0d, required 1 and %0d",
               cmd_ready_o, outstanding_o, MAXO - 1);
    end
    advance();
  endtask

  // Entered with three responses pending.
  task automatic test_simultaneous();
    respond(1);
    got_d_q.delete(); got_l_q.delete();
    push_word(32'h1234_5678);
    cmd_valid_i = 1'b1;
    cmd_len_i   = '0;
    b_valid_i   = 1'b1;
    sample();
    n_vec++;
    if (!(s_chs && s_bhs)) begin
      n_err++;
      $display("FAIL simul_hs: cmd_hs=%b b_hs=%b, required both 1", s_chs, s_bhs);
    end
    advance();
    cmd_valid_i = 1'b0;
    b_valid_i   = 1'b0;
    sample();
    n_vec++;
    if (outstanding_o !== CW'(2)) begin
      n_err++;
      $display("FAIL simul_count: outstanding=%0d, required 2", outstanding_o);
    end
    advance();
    drain_beats(1, 0, 20);
    respond(2);
  endtask

  task automatic test_max_len();
    logic [DW-1:0] exp_d[$];
    int n_last = 0;
    got_d_q.delete(); got_l_q.delete();
    gap_pct = 20;
    for (int i = 0; i < 256; i++) begin
      exp_d.push_back($urandom);
      buf_q.push_back(exp_d[i]);
    end
    drive_buf();
    do_cmd(255);
    drain_beats(256, 2, 3000);
    gap_pct = 0;
    n_vec++;
    if (got_d_q.size() != 256) begin
      n_err++;
      $display("FAIL max_count: %0d beats, required 256", got_d_q.size());
    end
    for (int i = 0; i < got_d_q.size() && i < 256; i++) begin
      if (got_l_q[i]) n_last++;
      n_vec++;
      if (got_d_q[i] !== exp_d[i]) begin
        n_err++;
        $display("FAIL max_data%0d: %h, required %h", i, got_d_q[i], exp_d[i]);
      end
    end
    n_vec++;
    if (n_last != 1 || got_l_q.size() < 256 || got_l_q[255] !== 1'b1) begin
      n_err++;
      $display("FAIL max_last: %0d last flags, required exactly one on beat 256", n_last);
    end
    push_word(32'hCAFE_F00D);
    for (int i = 0; i < 6; i++) begin sample(); advance(); end
    n_vec++;
    if (buf_q.size() != 1 || got_d_q.size() != 256) begin
      n_err++;
      $display("FAIL max_after: buffer holds %0d, beats %0d, required 1 and 256",
               buf_q.size(), got_d_q.size());
    end
    buf_q.delete();
    drive_buf();
    respond(1);
  endtask

  task automatic test_random_bursts();
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    int issued = 0;
    int cyc = 0;
    int left = 0;
    int len = 0;
    bit burst = 1'b0;
    got_d_q.delete(); got_l_q.delete();
    gap_pct = 30;
    while (cyc < 4000 && !(issued == 20 && !burst)) begin
      if (!cmd_valid_i && !burst && issued < 20 && $urandom_range(0, 2) == 0) begin
        len = $urandom_range(0, 15);
        cmd_len_i = LW'(len);
        cmd_valid_i = 1'b1;
        for (int k = 0; k <= len; k++) begin
          exp_d.push_back($urandom);
          exp_l.push_back(k == len);
          buf_q.push_back(exp_d[exp_d.size() - 1]);
        end
        drive_buf();
      end
      w_ready_i = ($urandom_range(0, 3) != 0);
      b_valid_i = ($urandom_range(0, 2) == 0);
      sample();
      n_vec++;
      if (cmd_ready_o !== (!burst && mdl_out < MAXO)) begin
        n_err++;
        $display("FAIL rnd_cmd_ready cyc%0d: %b, required %b", cyc, cmd_ready_o, (!burst && mdl_out < MAXO));
      end
      n_vec++;
      if (b_ready_o !== (mdl_out != 0) || outstanding_o !== CW'(mdl_out)) begin
        n_err++;
        $display("FAIL rnd_resp cyc%0d: b_ready=%b outstanding=%0d, required %b and %0d",
                 cyc, b_ready_o, outstanding_o, (mdl_out != 0), mdl_out);
      end
      n_vec++;
      if (busy_o !== (burst || mdl_out != 0)) begin
        n_err++;
        $display("FAIL rnd_busy cyc%0d: %b, required %b", cyc, busy_o, (burst || mdl_out != 0));
      end
      n_vec++;
      if (!burst && buf_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_idle_pop cyc%0d: buf_ready=%b outside a burst, required 0", cyc, buf_ready_o);
      end
      if (s_chs) begin
        burst = 1'b1;
        left  = len + 1;
        issued++;
      end else if (s_pop) begin
        left--;
        if (left == 0) burst = 1'b0;
      end
      advance();
      if (s_chs) cmd_valid_i = 1'b0;
      cyc++;
    end
    b_valid_i = 1'b0;
    gap_pct = 0;
    n_vec++;
    if (got_d_q.size() != exp_d.size()) begin
      n_err++;
      $display("FAIL rnd_count: %0d beats, required %0d", got_d_q.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d_q.size(); i++) begin
      n_vec++;
      if (got_d_q[i] !== exp_d[i] || got_l_q[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL rnd_beat%0d: data=%h last=%b, required data=%h last=%b",
                 i, got_d_q[i], got_l_q[i], exp_d[i], exp_l[i]);
      end
    end
    if (mdl_out > 0) respond(mdl_out);
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    got_d_q.delete(); got_l_q.delete();
    w_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) buf_q.push_back(32'h100 + DW'(i));
    drive_buf();
    do_cmd(7);
    while (got_d_q.size() < 3 && cyc < 20) begin
      sample();
      advance();
      cyc++;
    end
    rst_ni = 1'b0;
    mdl_out = 0;
    sample();
    n_vec++;
    if ({w_valid_o, w_last_o, buf_ready_o, b_ready_o, busy_o, cmd_ready_o} !== 6'b000001
        || w_data_o !== '0 || outstanding_o !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: {wv,wl,br,bk,busy,cr}=%b data=%h outstanding=%0d, required 000001 0 0",
               {w_valid_o, w_last_o, buf_ready_o, b_ready_o, busy_o, cmd_ready_o}, w_data_o, outstanding_o);
    end
    advance();
    sample();
    advance();
    rst_ni = 1'b1;
    sample();
    advance();
    n_vec++;
    if (buf_q.size() != 5 || got_d_q.size() != 3) begin
      n_err++;
      $display("FAIL midrst_abandon: buffer holds %0d, beats %0d, required 5 and 3",
               buf_q.size(), got_d_q.size());
    end
    buf_q.delete();
    drive_buf();
    got_d_q.delete(); got_l_q.delete();
    for (int i = 0; i < 3; i++) buf_q.push_back(32'h200 + DW'(i));
    drive_buf();
    do_cmd(2);
    drain_beats(3, 0, 20);
    for (int i = 0; i < 3 && i < got_d_q.size(); i++) begin
      n_vec++;
      if (got_d_q[i] !== 32'h200 + DW'(i) || got_l_q[i] !== (i == 2)) begin
        n_err++;
        $display("FAIL midrst_fresh%0d: data=%h last=%b, required data=%h last=%b",
                 i, got_d_q[i], got_l_q[i], 32'h200 + DW'(i), (i == 2));
      end
    end
    sample();
    n_vec++;
    if (outstanding_o !== CW'(1)) begin
      n_err++;
      $display("FAIL midrst_outstanding: %0d, required 1", outstanding_o);
    end
    advance();
    respond(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_max_len();
    test_random_bursts();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
